// File: rtl/f5_nand_arbiter_if.sv
// Request/grant and operand/result bundle for the shared f5 NAND arbiter.
// The requester side takes the master modport and the arbiter takes the slave modport.
interface f5_nand_arbiter_if #(
    parameter int W = 4
);
    logic [3:0]     req;
    logic [4*W-1:0] a_in;
    logic [4*W-1:0] b_in;
    logic [3:0]     gnt;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;
    logic [W-1:0]   s_out;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, done_id, s_out
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, done_id, s_out
    );
endinterface

// File: rtl/f5_nand_arbiter.sv
// Four-way arbiter that streams W-bit operand pairs LSB first through one shared f5 cell (~a | b).
// Define F5_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest); round-robin is the default.
//
// state  | meaning
// IDLE   | no operation; arbitrate on req and capture the winner's operands
// RUN    | one result bit per clock through the shared NAND cell
// DONE   | done pulse cycle; grant released and pointer advanced on exit
module f5_nand_arbiter #(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          reset,
    f5_nand_arbiter_if.slave bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d;
    logic [W-1:0]  res_q, res_d, s_q, s_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    win_q, win_d, id_q, id_d;
    logic          done_q, done_d;
    logic [1:0]    ptr;
    logic [1:0]    sel;
    logic          nand_n, nand_s;

`ifdef F5_ARB_FIXED_PRIO_EN
    assign ptr = 2'd0;
`else
    logic [1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (reset)
            ptr_q <= 2'd0;
        else if (state_q == S_DONE)
            ptr_q <= win_q + 2'd1;
    end

    assign ptr = ptr_q;
`endif

    // Walk offsets high to low so the nearest requester above ptr wins.
    always_comb begin
        sel = 2'd0;
        for (int off = 3; off >= 0; off--) begin
            if (bus.req[2'(ptr + 2'(off))])
                sel = 2'(ptr + 2'(off));
        end
    end

    // Shared f5 cell: two 2-input NANDs on the current LSBs.
    assign nand_n = ~(b_q[0] & b_q[0]);
    assign nand_s = ~(a_q[0] & nand_n);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        s_d     = s_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        id_d    = id_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                if (|bus.req) begin
                    a_d     = bus.a_in[sel*W +: W];
                    b_d     = bus.b_in[sel*W +: W];
                    gnt_d   = 4'b0001 << sel;
                    win_d   = sel;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d          = a_q >> 1;
                b_d          = b_q >> 1;
                res_d[idx_q] = nand_s;
                idx_d        = idx_q + 1'b1;
                if (idx_q == IW'(W - 1)) begin
                    s_d     = res_d;
                    id_d    = win_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = 4'b0000;
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            gnt_q   <= 4'b0000;
            win_q   <= 2'd0;
            id_q    <= 2'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            id_q    <= id_d;
            done_q  <= done_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.done_id = id_q;
    assign bus.s_out   = s_q;
endmodule

// File: tb/tb_f5_nand_arbiter.sv
// Self-checking bench for f5_nand_arbiter: randomized operands and request patterns
// compared against a vector-level reference (~a | b, round-robin or fixed-priority winner).
module tb_f5_nand_arbiter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    f5_nand_arbiter_if #(.W(W)) bus();

    f5_nand_arbiter #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ptr_m    = 0;

    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] f5_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        return ~a | b;
    endfunction

    function automatic int pick(input logic [3:0] r);
`ifdef F5_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++)
            if (r[i]) return i;
`else
        for (int off = 0; off < 4; off++)
            if (r[(ptr_m + off) % 4]) return (ptr_m + off) % 4;
`endif
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a_in[i*W +: W] = a;
        bus.b_in[i*W +: W] = b;
    endtask

    // Runs one operation from an idle DUT with req already driven; returns what was observed.
    task automatic run_op(output logic [3:0] g, output int lat, output logic [1:0] id,
                          output logic [W-1:0] s, output logic gnt_after,
                          output logic done_after, output int done_cyc);
        step();
        g   = bus.gnt;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        id       = bus.done_id;
        s        = bus.s_out;
        done_cyc = cyc;
        step();
        gnt_after  = |bus.gnt;
        done_after = bus.done;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        bus.req  = 4'b1111;
        bus.a_in = 16'($urandom);
        bus.b_in = 16'($urandom);
        step();
        step();
        n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.s_out !== '0) begin n_fail++; $display("FAIL reset_s_out: got %b expected 0", bus.s_out); end
        n_checks++; if (bus.done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d expected 0", bus.done_id); end
        bus.req = 4'b0000;
        reset   = 1'b0;
        ptr_m   = 0;
        step();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_single();
        logic [3:0] g; int lat; logic [1:0] id; logic [W-1:0] s; logic ga, da; int dc;
        set_op(0, 4'b1100, 4'b1010);
        bus.req = 4'b0001;
        run_op(g, lat, id, s, ga, da, dc);
        bus.req = 4'b0000;
        n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", g); end
        n_checks++; if (lat !== W) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, W); end
        n_checks++; if (s !== 4'b1011) begin n_fail++; $display("FAIL single_s_out: got %b expected 1011", s); end
        n_checks++; if (id !== 2'd0) begin n_fail++; $display("FAIL single_done_id: got %0d expected 0", id); end
        n_checks++; if (ga !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL single_release: got gnt %b done %b expected 0 0", ga, da); end
        ptr_m = 1;
        step();
        step();
        n_checks++; if (bus.s_out !== 4'b1011 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_hold: got s_out %b busy %b expected 1011 0", bus.s_out, bus.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] g; int lat; logic [1:0] id; logic [W-1:0] s; logic ga, da; int dc;
        logic [W-1:0] av[4], bv[4];
        int exp_w, prev_dc;
        prev_dc = 0;
        for (int i = 0; i < 4; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
            set_op(i, av[i], bv[i]);
        end
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_w = pick(4'b1111);
            run_op(g, lat, id, s, ga, da, dc);
            n_checks++; if (g !== 4'(1 << exp_w)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b expected %b", n, g, 4'(1 << exp_w)); end
            n_checks++; if (id !== 2'(exp_w)) begin n_fail++; $display("FAIL rr_done_id[%0d]: got %0d expected %0d", n, id, exp_w); end
            n_checks++; if (s !== f5_ref(av[exp_w], bv[exp_w])) begin n_fail++; $display("FAIL rr_s_out[%0d]: got %b expected %b", n, s, f5_ref(av[exp_w], bv[exp_w])); end
            if (n > 0) begin
                n_checks++; if (dc - prev_dc !== W + 2) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", n, dc - prev_dc, W + 2); end
            end
            prev_dc = dc;
            ptr_m = (exp_w + 1) % 4;
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_operand_stability();
        int lat;
        set_op(2, 4'b0000, 4'b0000);
        bus.req = 4'b0100;
        step();
        n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL stab_gnt: got %b expected 0100", bus.gnt); end
        step();
        bus.a_in[2*W +: W] = 4'b1111;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_checks++; if (lat !== W) begin n_fail++; $display("FAIL stab_latency: got %0d expected %0d", lat, W); end
        n_checks++; if (bus.s_out !== 4'b1111) begin n_fail++; $display("FAIL stab_s_out: got %b expected 1111", bus.s_out); end
        n_checks++; if (bus.done_id !== 2'd2) begin n_fail++; $display("FAIL stab_done_id: got %0d expected 2", bus.done_id); end
        bus.req = 4'b0000;
        ptr_m = 3;
        step();
    endtask

    task automatic test_reset_mid_run();
        int seen_done;
        set_op(1, W'($urandom), W'($urandom));
        bus.req = 4'b0010;
        step();
        n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL midrst_gnt: got %b expected 0010", bus.gnt); end
        step();
        reset   = 1'b1;
        bus.req = 4'b0000;
        step();
        reset = 1'b0;
        n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got gnt %b busy %b done %b expected 0000 0 0", bus.gnt, bus.busy, bus.done); end
        n_checks++; if (bus.s_out !== '0 || bus.done_id !== 2'd0) begin n_fail++; $display("FAIL midrst_result: got s_out %b done_id %0d expected 0 0", bus.s_out, bus.done_id); end
        seen_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.done === 1'b1) seen_done++;
        end
        n_checks++; if (seen_done !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses expected 0", seen_done); end
        ptr_m = 0;
    endtask

    task automatic test_request_drop();
        logic [W-1:0] a3, b3;
        int lat;
        a3 = W'($urandom);
        b3 = W'($urandom);
        set_op(3, a3, b3);
        bus.req = 4'b1000;
        step();
        n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL drop_gnt: got %b expected 1000", bus.gnt); end
        bus.req = 4'b0000;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_checks++; if (lat !== W) begin n_fail++; $display("FAIL drop_latency: got %0d expected %0d", lat, W); end
        n_checks++; if (bus.done_id !== 2'd3) begin n_fail++; $display("FAIL drop_done_id: got %0d expected 3", bus.done_id); end
        n_checks++; if (bus.s_out !== f5_ref(a3, b3)) begin n_fail++; $display("FAIL drop_s_out: got %b expected %b", bus.s_out, f5_ref(a3, b3)); end
        step();
        step();
        step();
        n_checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got gnt %b busy %b expected 0000 0", bus.gnt, bus.busy); end
        ptr_m = 0;
    endtask

    task automatic test_random();
        logic [3:0] g; int lat; logic [1:0] id; logic [W-1:0] s; logic ga, da; int dc;
        logic [W-1:0] av[4], bv[4];
        logic [3:0] r;
        int exp_w;
        for (int n = 0; n < 20; n++) begin
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                av[i] = W'($urandom);
                bv[i] = W'($urandom);
                set_op(i, av[i], bv[i]);
            end
            bus.req = r;
            exp_w = pick(r);
            run_op(g, lat, id, s, ga, da, dc);
            n_checks++; if (g !== 4'(1 << exp_w)) begin n_fail++; $display("FAIL rand_gnt[%0d]: req %b got %b expected %b", n, r, g, 4'(1 << exp_w)); end
            n_checks++; if (lat !== W) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, W); end
            n_checks++; if (id !== 2'(exp_w)) begin n_fail++; $display("FAIL rand_done_id[%0d]: got %0d expected %0d", n, id, exp_w); end
            n_checks++; if (s !== f5_ref(av[exp_w], bv[exp_w])) begin n_fail++; $display("FAIL rand_s_out[%0d]: got %b expected %b", n, s, f5_ref(av[exp_w], bv[exp_w])); end
            n_checks++; if (ga !== 1'b0 || da !== 1'b0) begin n_fail++; $display("FAIL rand_release[%0d]: got gnt %b done %b expected 0 0", n, ga, da); end
            ptr_m = (exp_w + 1) % 4;
        end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        reset    = 1'b1;
        bus.req  = 4'b0000;
        bus.a_in = '0;
        bus.b_in = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_operand_stability();
        test_reset_mid_run();
        test_request_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end
endmodule
